serial_tx: RTL and testbench

- Frame-based serial transmitter, the sending end of the team's single-bit serial link.
- Accepts a parallel word over a valid/ready handshake, then shifts it out on one line as start bit, data LSB-first, optional even parity, and stop bit.
- Each bit is held for a programmable number of clocks.
- Sits between a parallel producer (CPU/lab datapath) and the serial line consumed by the matching receiver.

---
 rtl/serial_tx.sv | 154 +++++++++++++++
 tb/tb_serial_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Purpose : frame serializer; start bit, WIDTH data bits LSB-first, optional
//           even parity, stop bit, each bit held CLKS_PER_BIT clocks.
// Latency : first start-bit cycle is the cycle after the accept edge; the
//           frame takes (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles, then done pulses.
// Backpressure: in_ready only in IDLE; in_valid while a frame is in flight is
//           ignored and the producer holds its word until in_ready returns.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   in_valid producer has a word on in_data
//   in_data  word to transmit (WIDTH bits)
//   in_ready block can accept a word this cycle (combinational from state)
//   tx       serial line, idles high (registered)
//   busy     frame in progress (registered)
//   done     one-cycle pulse on the first IDLE cycle after a frame (registered)
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Counters keep at least one bit so CLKS_PER_BIT=1 / WIDTH=1 still elaborate.
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_q, div_nxt;
    logic [BIT_W-1:0]   bit_q, bit_nxt;
    logic [WIDTH-1:0]   shreg_q, shreg_nxt;
    logic [WIDTH-1:0]   shreg_shifted;
    logic               par_q, par_nxt;
    logic               tx_nxt, busy_nxt, done_nxt;
    logic               bit_end;

    assign in_ready      = (state == IDLE);
    assign bit_end       = (div_q == DIV_LAST);
    assign shreg_shifted = shreg_q >> 1;

    // tx/busy/done are computed for the *next* state so that they come out
    // of flops aligned with the state they describe.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_q;
        bit_nxt   = bit_q;
        shreg_nxt = shreg_q;
        par_nxt   = par_q;
        tx_nxt    = tx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        if (state != IDLE) begin
            div_nxt = bit_end ? '0 : div_q + DIV_W'(1);
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = START;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    shreg_nxt = in_data;
                    par_nxt   = ^in_data;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_q + BIT_W'(1);
                        shreg_nxt = shreg_shifted;
                        tx_nxt    = shreg_shifted[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_q   <= div_nxt;
            bit_q   <= bit_nxt;
            shreg_q <= shreg_nxt;
            par_q   <= par_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Purpose : self-checking bench for serial_tx in three configurations
//           (8b/4clk, 8b/4clk+parity, 4b/1clk).
// Latency : cycle-exact checks of tx/busy/done/in_ready against a bit model.
// Backpressure: back-to-back words with in_valid held high through busy.
module tb_serial_tx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic [3:0] d2 = '0;
    logic       r0, r1, r2, tx0, tx1, tx2, b0, b1, b2, dn0, dn1, dn2;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0),
        .in_ready(r0), .tx(tx0), .busy(b0), .done(dn0));
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
        .in_ready(r1), .tx(tx1), .busy(b1), .done(dn1));
    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2),
        .in_ready(r2), .tx(tx2), .busy(b2), .done(dn2));

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        int         len;
    } vec_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {in_ready, tx, busy, done} of the selected instance
    function automatic logic [3:0] outs(input int s);
        case (s)
            0:       return {r0, tx0, b0, dn0};
            1:       return {r1, tx1, b1, dn1};
            default: return {r2, tx2, b2, dn2};
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin v0 = v; d0 = d;      end
            1:       begin v1 = v; d1 = d;      end
            default: begin v2 = v; d2 = d[3:0]; end
        endcase
    endtask

    // Line decoder: on a falling tx edge, samples each bit mid-period and
    // checks the recovered frame against the oldest expected word.
    task automatic mon(input int s);
        int         c, w, nb, pos, tgt;
        logic       prev, bv, ab, pbit, stop_ok;
        logic [3:0] o;
        logic [7:0] d;
        exp_t       e;
        c    = (s == 2) ? 1 : 4;
        w    = (s == 2) ? 4 : 8;
        nb   = w + 1 + ((s == 1) ? 1 : 0);
        prev = 1'b1;
        forever begin
            @(negedge clk);
            o  = outs(s);
            bv = o[2];
            if (!reset) begin
                prev = 1'b1;
            end else if (prev && !bv) begin
                d = '0; pbit = 1'b0; stop_ok = 1'b0; ab = 1'b0; pos = 0;
                for (int k = 1; k <= nb; k++) begin
                    tgt = k * c + c / 2;
                    while (pos < tgt && !ab) begin
                        @(negedge clk);
                        pos++;
                        if (!reset) ab = 1'b1;
                    end
                    if (ab) break;
                    o  = outs(s);
                    bv = o[2];
                    if (k <= w)       d[k-1]  = bv;
                    else if (k == nb) stop_ok = bv;
                    else              pbit    = bv;
                end
                if (!ab) begin
                    if (sb.size() == 0) begin
                        n_run++;
                        n_fail++;
                        $display("FAIL sb_extra_frame: inst %0d sent 0x%0h, nothing expected", s, d);
                    end else begin
                        e = sb.pop_front();
                        n_pop++;
                        chk("sb_sel", s, e.sel);
                        chk("sb_data", 32'(d), 32'(e.data));
                        if (s == 1) chk("sb_parity", 32'(pbit), 32'(e.par));
                        chk("sb_stop", 32'(stop_ok), 32'd1);
                    end
                end
                prev = 1'b1;
            end else begin
                prev = bv;
            end
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input int s, input logic [7:0] d, input logic p, input int len);
        int   b;
        logic eb;
        sb.push_back('{s, d, p});
        n_push++;
        drive(s, 1'b1, d);
        @(posedge clk); #1;
        drive(s, 1'b0, ~d);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            b = k / 4;
            if (b == 0)                  eb = 1'b0;
            else if (b <= 8)             eb = d[b-1];
            else if (s == 1 && b == 9)   eb = p;
            else                         eb = 1'b1;
            chk($sformatf("frame_%0h_cyc%0d", d, k), 32'(outs(s)), 32'({1'b0, eb, 2'b10}));
        end
        @(negedge clk);
        chk($sformatf("frame_%0h_done", d), 32'(outs(s)), 32'(4'b1101));
        @(negedge clk);
        chk($sformatf("frame_%0h_idle", d), 32'(outs(s)), 32'(4'b1100));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[7];
        logic [0:5] seq;
        int         gap;
        logic       found;

        tbl[0] = '{0, 8'hA5, 1'b0, 40};
        tbl[1] = '{0, 8'h00, 1'b0, 40};
        tbl[2] = '{0, 8'hFF, 1'b0, 40};
        tbl[3] = '{1, 8'h07, 1'b1, 44};
        tbl[4] = '{1, 8'h03, 1'b0, 44};
        tbl[5] = '{1, 8'h80, 1'b1, 44};
        tbl[6] = '{1, 8'hFF, 1'b0, 44};

        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        // Reset, then a long idle stretch
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++)
                chk($sformatf("reset_inst%0d", s), 32'(outs(s)), 32'(4'b1100));
        end
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("idle_cyc%0d", i), 32'(outs(0)), 32'(4'b1100));
        end
        @(posedge clk); #1;

        // Single frames from the vector table
        for (int i = 0; i < 7; i++)
            send_frame(tbl[i].sel, tbl[i].data, tbl[i].par, tbl[i].len);

        // Back-to-back: in_valid held high across the whole first frame
        sb.push_back('{0, 8'h01, 1'b0});
        sb.push_back('{0, 8'hFF, 1'b0});
        n_push += 2;
        drive(0, 1'b1, 8'h01);
        @(posedge clk); #1 drive(0, 1'b1, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dn0) begin found = 1'b1; break; end
        end
        chk("b2b_done1_seen", 32'(found), 32'd1);
        chk("b2b_done1_outs", 32'(outs(0)), 32'(4'b1101));
        @(posedge clk); #1 drive(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("b2b_start2", 32'(outs(0)), 32'(4'b0010));
        gap = 1; found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            gap++;
            if (dn0) begin found = 1'b1; break; end
        end
        chk("b2b_done2_seen", 32'(found), 32'd1);
        chk("b2b_done_gap", gap, 41);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("b2b_no_dup", 32'(outs(0)), 32'(4'b1100));
        end

        // Reset during DATA bit 3 of 0x5A, then 0x3C on the first edge after release
        @(posedge clk); #1 drive(0, 1'b1, 8'h5A);
        @(posedge clk); #1 drive(0, 1'b0, 8'h00);
        for (int k = 0; k <= 17; k++) @(negedge clk);
        chk("midrst_in_frame", 32'(outs(0)), 32'(4'b0110));
        #1 reset = 1'b0;
        #1 chk("midrst_async", 32'(outs(0)), 32'(4'b1100));
        @(negedge clk);
        chk("midrst_no_done", 32'(outs(0)), 32'(4'b1100));
        @(posedge clk); #1 reset = 1'b1;
        send_frame(0, 8'h3C, 1'b0, 40);

        // Reset asserted together with an accept: nothing latched
        drive(0, 1'b1, 8'h77);
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wins", 32'(outs(0)), 32'(4'b1100));
        @(posedge clk); #1;

        // One clock per bit, WIDTH=4
        sb.push_back('{2, 8'h09, 1'b0});
        n_push++;
        seq = 6'b010011;
        drive(2, 1'b1, 8'h09);
        @(posedge clk); #1 drive(2, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("fast_cyc%0d", k), 32'(outs(2)), 32'({1'b0, seq[k], 2'b10}));
        end
        @(negedge clk);
        chk("fast_done", 32'(outs(2)), 32'(4'b1101));
        @(negedge clk);
        chk("fast_idle", 32'(outs(2)), 32'(4'b1100));

        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("sb_pops", n_pop, n_push);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
